// File: rtl/seq_linear_classifier.sv
// Weight-streaming linear classifier: latches a feature vector, performs one MAC per accepted
// weight word and tracks the running argmax over all class scores.
module seq_linear_classifier #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned FEATURES = 2,
    parameter int unsigned C_WIDTH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FEATURES*WIDTH-1:0] features,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [WIDTH-1:0]          weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          r_value,
    output logic [C_WIDTH-1:0]        r_class
);

    localparam int unsigned FW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam logic [FW-1:0] FLast = FW'(FEATURES - 1);
    localparam logic [C_WIDTH-1:0] CLast = '1;

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                    state_q, state_d;
    logic [FEATURES*WIDTH-1:0] feat_q, feat_d;
    logic [WIDTH-1:0]          acc_q, acc_d;
    logic [WIDTH-1:0]          best_q, best_d;
    logic [WIDTH-1:0]          r_value_q, r_value_d;
    logic [FW-1:0]             f_cnt_q, f_cnt_d;
    logic [C_WIDTH-1:0]        c_cnt_q, c_cnt_d;
    logic [C_WIDTH-1:0]        best_idx_q, best_idx_d;
    logic [C_WIDTH-1:0]        r_class_q, r_class_d;

    logic [WIDTH-1:0]   cur_feat, prod, acc_n, fin_best;
    logic [C_WIDTH-1:0] fin_idx;

    // Handshake readies are forced low while reset is held.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign w_ready   = (state_q == StAccum) && !rst;
    assign out_valid = (state_q == StDone) && !rst;
    assign r_value   = r_value_q;
    assign r_class   = r_class_q;

    assign cur_feat = feat_q[f_cnt_q*WIDTH +: WIDTH];
    assign prod     = WIDTH'(cur_feat * weight);
    assign acc_n    = acc_q + prod;

    always_comb begin
        state_d    = state_q;
        feat_d     = feat_q;
        acc_d      = acc_q;
        f_cnt_d    = f_cnt_q;
        c_cnt_d    = c_cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        r_value_d  = r_value_q;
        r_class_d  = r_class_q;
        fin_best   = best_q;
        fin_idx    = best_idx_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    feat_d  = features;
                    acc_d   = '0;
                    f_cnt_d = '0;
                    c_cnt_d = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (w_valid) begin
                    if (f_cnt_q != FLast) begin
                        acc_d   = acc_n;
                        f_cnt_d = f_cnt_q + 1'b1;
                    end else begin
                        // Strict compare: ties keep the earlier (lower) class index.
                        if (c_cnt_q == '0 || acc_n > best_q) begin
                            fin_best = acc_n;
                            fin_idx  = c_cnt_q;
                        end
                        best_d     = fin_best;
                        best_idx_d = fin_idx;
                        acc_d      = '0;
                        f_cnt_d    = '0;
                        if (c_cnt_q == CLast) begin
                            r_value_d = fin_best;
                            r_class_d = fin_idx;
                            state_d   = StDone;
                        end else begin
                            c_cnt_d = c_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            feat_q     <= '0;
            acc_q      <= '0;
            f_cnt_q    <= '0;
            c_cnt_q    <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            r_value_q  <= '0;
            r_class_q  <= '0;
        end else begin
            state_q    <= state_d;
            feat_q     <= feat_d;
            acc_q      <= acc_d;
            f_cnt_q    <= f_cnt_d;
            c_cnt_q    <= c_cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            r_value_q  <= r_value_d;
            r_class_q  <= r_class_d;
        end
    end

endmodule

// File: tb/tb_seq_linear_classifier.sv
// Bench for seq_linear_classifier: directed scenarios plus randomized vectors checked against an
// arithmetic reference model, on a default instance and a 4-class/3-feature instance.
module tb_seq_linear_classifier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_w_valid = 1'b0, a_out_ready = 1'b0;
    logic        a_in_ready, a_w_ready, a_out_valid;
    logic [15:0] a_features = '0;
    logic [7:0]  a_weight = '0;
    logic [7:0]  a_r_value;
    logic [0:0]  a_r_class;

    logic        b_in_valid = 1'b0, b_w_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_w_ready, b_out_valid;
    logic [23:0] b_features = '0;
    logic [7:0]  b_weight = '0;
    logic [7:0]  b_r_value;
    logic [1:0]  b_r_class;

    seq_linear_classifier u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .features(a_features),
        .w_valid(a_w_valid), .w_ready(a_w_ready), .weight(a_weight),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .r_value(a_r_value), .r_class(a_r_class)
    );

    seq_linear_classifier #(.WIDTH(8), .FEATURES(3), .C_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .features(b_features),
        .w_valid(b_w_valid), .w_ready(b_w_ready), .weight(b_weight),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .r_value(b_r_value), .r_class(b_r_class)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] res_val;
    int res_cls, res_lat, res_wcnt;
    bit res_done, res_stable, res_post_ir, res_post_ov, sim_w;

    // Score of class c is the mod-256 dot product of features with weight words c*nf .. c*nf+nf-1.
    function automatic void ref_model(input int nf, input int nc, input logic [63:0] fpk,
                                      input logic [127:0] wpk, output int val, output int cls);
        int s;
        val = 0;
        cls = 0;
        for (int c = 0; c < nc; c++) begin
            s = 0;
            for (int i = 0; i < nf; i++)
                s += int'(fpk[i*8 +: 8]) * int'(wpk[(c*nf+i)*8 +: 8]);
            s = s % 256;
            if (c == 0 || s > val) begin
                val = s;
                cls = c;
            end
        end
    endfunction

    // wstall < 0 selects random gaps between weights; ostall holds out_ready low that many cycles.
    task automatic run_a(input logic [15:0] feats, input logic [31:0] wpk, input int wstall,
                         input int ostall);
        int idx = 0, gap = 0, ostl = 0, n = 0;
        logic [7:0] v0 = '0;
        logic [0:0] c0 = '0;
        res_done = 0; res_lat = 0; res_stable = 1;
        @(negedge clk);
        a_in_valid = 1; a_features = feats; a_out_ready = 0;
        a_w_valid = sim_w; a_weight = 8'd200;
        while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
        if (!a_in_ready) return;
        for (int k = 1; k <= 200 && !res_done; k++) begin
            @(negedge clk);
            a_in_valid = 0;
            if (a_out_valid) begin
                if (res_lat == 0) begin res_lat = k; v0 = a_r_value; c0 = a_r_class; end
                if (a_r_value !== v0 || a_r_class !== c0) res_stable = 0;
                a_w_valid = 0;
                if (ostl < ostall) begin
                    a_out_ready = 0; ostl++;
                end else begin
                    a_out_ready = 1; res_val = a_r_value; res_cls = int'(a_r_class);
                    res_done = 1;
                end
            end else begin
                a_out_ready = 0;
                if (idx < 4 && gap == 0) begin
                    a_w_valid = 1; a_weight = wpk[idx*8 +: 8];
                    if (a_w_ready) begin
                        idx++;
                        gap = (wstall < 0) ? int'($urandom_range(0, 2)) : wstall;
                    end
                end else begin
                    a_w_valid = 0;
                    if (gap > 0) gap--;
                end
            end
        end
        @(negedge clk);
        a_out_ready = 0;
        res_post_ir = a_in_ready;
        res_post_ov = a_out_valid;
    endtask

    task automatic run_b(input logic [23:0] feats, input logic [95:0] wpk, input bit rnd);
        int idx = 0, gap = 0, n = 0;
        res_done = 0; res_lat = 0; res_wcnt = 0;
        @(negedge clk);
        b_in_valid = 1; b_features = feats;
        while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
        if (!b_in_ready) return;
        for (int k = 1; k <= 300 && !res_done; k++) begin
            @(negedge clk);
            b_in_valid = 0;
            if (b_out_valid) begin
                b_w_valid = 0; b_out_ready = 1; res_lat = k; res_wcnt = idx;
                res_val = b_r_value; res_cls = int'(b_r_class); res_done = 1;
            end else if (idx < 12 && gap == 0) begin
                b_w_valid = 1; b_weight = wpk[idx*8 +: 8];
                if (b_w_ready) begin
                    idx++;
                    gap = rnd ? int'($urandom_range(0, 1)) : 0;
                end
            end else begin
                b_w_valid = 0;
                if (gap > 0) gap--;
            end
        end
        @(negedge clk);
        b_out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", a_in_ready); end
        total++; if (a_w_ready !== 1'b0) begin bad++; $display("FAIL rst_w_ready got=%b want=0", a_w_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", a_out_valid); end
        rst = 0;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", a_in_ready); end
        total++; if (a_r_value !== 8'd0 || a_r_class !== 1'b0) begin
            bad++; $display("FAIL rst_result got=%0d/%0d want=0/0", a_r_value, a_r_class);
        end
    endtask

    task automatic test_basic();
        run_a(16'h0403, 32'h01020201, 0, 0);
        total++; if (!res_done) begin bad++; $display("FAIL basic_timeout got=none want=result"); end
        total++; if (res_val !== 8'd11 || res_cls !== 0) begin
            bad++; $display("FAIL basic_result got=%0d/%0d want=11/0", res_val, res_cls);
        end
        total++; if (res_lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", res_lat); end
    endtask

    task automatic test_tie();
        run_a(16'h0403, 32'h01010101, 0, 0);
        total++; if (res_val !== 8'd7 || res_cls !== 0 || !res_done) begin
            bad++; $display("FAIL tie_result got=%0d/%0d want=7/0", res_val, res_cls);
        end
    endtask

    task automatic test_wrap();
        run_a(16'h1010, 32'h00010010, 0, 0);
        total++; if (res_val !== 8'd16 || res_cls !== 1 || !res_done) begin
            bad++; $display("FAIL wrap_result got=%0d/%0d want=16/1", res_val, res_cls);
        end
    endtask

    task automatic test_backpressure();
        run_a(16'h0403, 32'h01020201, 2, 3);
        total++; if (res_val !== 8'd11 || res_cls !== 0 || !res_done) begin
            bad++; $display("FAIL bp_result got=%0d/%0d want=11/0", res_val, res_cls);
        end
        total++; if (res_stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1", res_stable); end
        total++; if (res_post_ir !== 1'b1 || res_post_ov !== 1'b0) begin
            bad++; $display("FAIL bp_after_handshake got=ir%b/ov%b want=ir1/ov0", res_post_ir, res_post_ov);
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0, n = 0, ov_seen = 0;
        logic [31:0] wpk = 32'h01020201;
        total++; if (a_r_value !== 8'd16 || a_r_class !== 1'b1) begin
            bad++; $display("FAIL result_retained got=%0d/%0d want=16/1", a_r_value, a_r_class);
        end
        @(negedge clk);
        a_in_valid = 1; a_features = 16'h0403;
        @(negedge clk);
        a_in_valid = 0;
        while (idx < 3 && n < 50) begin
            a_w_valid = 1; a_weight = wpk[idx*8 +: 8];
            if (a_w_ready) idx++;
            @(negedge clk);
            n++;
        end
        a_w_valid = 0;
        rst = 1;
        #1;
        total++; if (a_out_valid !== 1'b0 || a_w_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=ov%b/wr%b want=ov0/wr0", a_out_valid, a_w_ready);
        end
        @(negedge clk);
        rst = 0;
        #1;
        total++; if (a_in_ready !== 1'b1 || a_w_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_idle got=ir%b/wr%b want=ir1/wr0", a_in_ready, a_w_ready);
        end
        total++; if (a_r_value !== 8'd0 || a_r_class !== 1'b0) begin
            bad++; $display("FAIL midrst_result got=%0d/%0d want=0/0", a_r_value, a_r_class);
        end
        for (int k = 0; k < 6; k++) begin
            a_w_valid = 1; a_weight = 8'd1;
            @(negedge clk);
            if (a_out_valid) ov_seen++;
        end
        a_w_valid = 0;
        total++; if (ov_seen !== 0) begin bad++; $display("FAIL midrst_no_out got=%0d want=0", ov_seen); end
        run_a(16'h0403, 32'h01020201, 0, 0);
        total++; if (res_val !== 8'd11 || res_cls !== 0 || !res_done) begin
            bad++; $display("FAIL midrst_rerun got=%0d/%0d want=11/0", res_val, res_cls);
        end
    endtask

    task automatic test_simultaneous();
        sim_w = 1;
        run_a(16'h0403, 32'h01020201, 0, 0);
        sim_w = 0;
        total++; if (res_val !== 8'd11 || res_cls !== 0 || res_lat !== 5) begin
            bad++; $display("FAIL simul_result got=%0d/%0d lat=%0d want=11/0 lat=5", res_val, res_cls, res_lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] f;
        logic [31:0] w;
        int ev, ec;
        for (int it = 0; it < 25; it++) begin
            f = 16'($urandom);
            w = $urandom;
            if ($urandom_range(0, 1) == 1) begin f &= 16'h0303; w &= 32'h03030303; end
            ref_model(2, 2, 64'(f), 128'(w), ev, ec);
            run_a(f, w, -1, int'($urandom_range(0, 2)));
            total++; if (res_val !== 8'(ev) || res_cls !== ec || !res_done) begin
                bad++; $display("FAIL rand_a[%0d] got=%0d/%0d want=%0d/%0d", it, res_val, res_cls, ev, ec);
            end
        end
    endtask

    task automatic test_wide();
        logic [23:0] f;
        logic [95:0] w;
        int ev, ec;
        run_b(24'h030201, 96'h000009020202050000010101, 0);
        total++; if (res_val !== 8'd15 || res_cls !== 1 || !res_done) begin
            bad++; $display("FAIL wide_result got=%0d/%0d want=15/1", res_val, res_cls);
        end
        total++; if (res_lat !== 13 || res_wcnt !== 12) begin
            bad++; $display("FAIL wide_latency got=lat%0d/w%0d want=lat13/w12", res_lat, res_wcnt);
        end
        for (int it = 0; it < 8; it++) begin
            f = 24'($urandom);
            w = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) w &= {12{8'h03}};
            ref_model(3, 4, 64'(f), 128'(w), ev, ec);
            run_b(f, w, 1'b1);
            total++; if (res_val !== 8'(ev) || res_cls !== ec || !res_done) begin
                bad++; $display("FAIL rand_b[%0d] got=%0d/%0d want=%0d/%0d", it, res_val, res_cls, ev, ec);
            end
        end
    endtask

    initial begin
        sim_w = 0;
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_simultaneous();
        test_random();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
